// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the RV64M divide group (DIV/DIVU/REM/REMU and W-forms).
// Divide-by-zero, signed overflow and W-form sign extension are resolved inside the unit.
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic            div_rem,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int unsigned WLEN = 32;
  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            word_q, word_d;
  logic            rsel_q, rsel_d;

  logic accept;
  logic special;
  logic last;

  function automatic logic [XLEN-1:0] wsext(input logic word, input logic [XLEN-1:0] val);
    return word ? {{(XLEN-WLEN){val[WLEN-1]}}, val[WLEN-1:0]} : val;
  endfunction

  // Operand preparation, evaluated on the request inputs at accept time
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, a_align, min_val, special_sel;
  logic            a_neg, b_neg, b_zero, ovf;

  always_comb begin
    if (div_word) begin
      a_ext   = {{(XLEN-WLEN){div_signed & div_src1[WLEN-1]}}, div_src1[WLEN-1:0]};
      b_ext   = {{(XLEN-WLEN){div_signed & div_src2[WLEN-1]}}, div_src2[WLEN-1:0]};
      min_val = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
    end else begin
      a_ext   = div_src1;
      b_ext   = div_src2;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg   = div_signed & a_ext[XLEN-1];
    b_neg   = div_signed & b_ext[XLEN-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    // Left-align W-form dividends so both widths shift out from the register MSB
    a_align = div_word ? (a_abs << WLEN) : a_abs;
    b_zero  = (b_ext == '0);
    ovf     = div_signed & (a_ext == min_val) & (b_ext == '1);
    special = b_zero | ovf;
    if (b_zero) begin
      special_sel = div_rem ? a_ext : '1;
    end else begin
      special_sel = div_rem ? '0 : a_ext;
    end
  end

  // One restoring step: the partial remainder never exceeds the divisor, so XLEN+1 bits suffice
  logic [XLEN:0]   trial, diff;
  logic            qbit;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix, calc_res;

  always_comb begin
    trial    = {rem_q, quo_q[XLEN-1]};
    diff     = trial - {1'b0, dvsr_q};
    qbit     = ~diff[XLEN];
    rem_nx   = qbit ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx   = {quo_q[XLEN-2:0], qbit};
    q_fix    = qneg_q ? -quo_nx : quo_nx;
    r_fix    = rneg_q ? -rem_nx : rem_nx;
    calc_res = wsext(word_q, rsel_q ? r_fix : q_fix);
    last     = (cnt_q == (word_q ? CntW'(WLEN - 1) : CntW'(XLEN - 1)));
  end

  assign accept = div_valid & div_ready & ~flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = special ? StDone : StCalc;
      StCalc: if (last) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // Output decode
  always_comb begin
    div_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  div_ready = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_result = res_q;

  // Datapath next-state
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    word_d = word_q;
    rsel_d = rsel_q;
    if (accept) begin
      quo_d  = a_align;
      rem_d  = '0;
      dvsr_d = b_abs;
      cnt_d  = '0;
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
      word_d = div_word;
      rsel_d = div_rem;
      if (special) res_d = wsext(div_word, special_sel);
    end else if (state_q == StCalc && !flush) begin
      quo_d = quo_nx;
      rem_d = rem_nx;
      cnt_d = cnt_q + CntW'(1);
      if (last) res_d = calc_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      word_q <= 1'b0;
      rsel_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      word_q <= word_d;
      rsel_q <= rsel_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus randomized ops checked against
// a plain-arithmetic RISC-V divide model, with latency, hold, flush and reset scenarios.
module tb_div_unit;
  timeunit 1ns;
  timeprecision 1ns;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            div_valid = 1'b0;
  logic            div_ready;
  logic            div_signed = 1'b0;
  logic            div_word = 1'b0;
  logic            div_rem = 1'b0;
  logic [XLEN-1:0] div_src1 = '0;
  logic [XLEN-1:0] div_src2 = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_result;

  div_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .div_word   (div_word),
    .div_rem    (div_rem),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    longint      lat;
    longint      t_acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V divide semantics from plain arithmetic
  function automatic logic [63:0] ref_result(input bit sgn, input bit wrd, input bit rem,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (wrd) begin
      if (b32 == 0) r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'h0 : a32;
      else if (sgn) r32 = rem ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      else r32 = rem ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 0) r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      r64 = rem ? 64'h0 : a;
    else if (sgn) r64 = rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    else r64 = rem ? a % b : a / b;
    return r64;
  endfunction

  function automatic longint ref_latency(input bit sgn, input bit wrd,
                                         input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    if (wrd) begin
      zero = (b[31:0] == 0);
      ovf  = sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end else begin
      zero = (b == 0);
      ovf  = sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF;
    end
    if (zero || ovf) return 1;
    return wrd ? 33 : 65;
  endfunction

  // Monitor: compares every cycle the DUT presents a result
  initial begin
    bit in_done;
    in_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !out_valid) begin
        in_done = 0;
      end else if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got out_valid=1 result=%h expected no result", out_result);
      end else begin
        if (!in_done) begin
          in_done = 1;
          check64("latency", 64'(($time + 5 - sb[0].t_acc) / 10), 64'(sb[0].lat));
        end
        check64("result", out_result, sb[0].res);
        check64("ready_low_busy", 64'(div_ready), 64'd0);
        if (out_ready && !flush) begin
          void'(sb.pop_front());
          in_done = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit sgn, input bit wrd, input bit rem,
                       input logic [63:0] a, input logic [63:0] b, input bit expect_res);
    exp_t e;
    int   n;
    n = 0;
    while (!div_ready && n < 200) begin
      step();
      n++;
    end
    check64("ready_before_issue", 64'(div_ready), 64'd1);
    div_signed = sgn;
    div_word   = wrd;
    div_rem    = rem;
    div_src1   = a;
    div_src2   = b;
    div_valid  = 1'b1;
    @(posedge clk);
    if (expect_res) begin
      e.res   = ref_result(sgn, wrd, rem, a, b);
      e.lat   = ref_latency(sgn, wrd, a, b);
      e.t_acc = $time;
      sb.push_back(e);
    end
    #1;
    // Scramble the request after accept; the unit must have captured its operands
    div_valid  = 1'b0;
    div_signed = 1'($urandom);
    div_word   = 1'($urandom);
    div_rem    = 1'($urandom);
    div_src1   = {$urandom, $urandom};
    div_src2   = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check64("done_timeout", 64'(sb.size()), 64'd0);
    if (sb.size() != 0) begin
      sb.delete();
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
  endtask

  task automatic run_op(input bit sgn, input bit wrd, input bit rem,
                        input logic [63:0] a, input logic [63:0] b);
    issue(sgn, wrd, rem, a, b, 1'b1);
    wait_done();
  endtask

  function automatic logic [63:0] rand_operand(input bit divisor);
    unique case ($urandom_range(0, 7))
      0:       return divisor ? 64'h0 : 64'h8000_0000_0000_0000;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'($urandom_range(0, 20));
      3:       return {32'($urandom), 32'h8000_0000};
      4:       return 64'($signed(32'($urandom)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values
    #12;
    check64("reset_out_valid", 64'(out_valid), 64'd0);
    check64("reset_out_result", out_result, 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    check64("ready_after_reset", 64'(div_ready), 64'd1);
    step();

    // Directed cases
    run_op(0, 0, 0, 64'd100, 64'd7);
    run_op(0, 0, 1, 64'd100, 64'd7);
    run_op(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    run_op(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    run_op(0, 0, 0, 64'd5, 64'd0);
    run_op(0, 0, 1, 64'd5, 64'd0);
    run_op(1, 1, 0, 64'd5, 64'd0);
    run_op(1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(1, 0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(1, 1, 0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(0, 1, 0, 64'h1234_5678_FFFF_FFFE, 64'd1);
    run_op(0, 1, 1, 64'h1234_5678_FFFF_FFFE, 64'd7);

    // Result held while the consumer stalls
    out_ready = 1'b0;
    issue(0, 0, 0, 64'd100, 64'd7, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check64("hold_valid_seen", 64'(out_valid), 64'd1);
    repeat (5) step();
    out_ready = 1'b1;
    wait_done();

    // Flush mid-calculation drops the operation
    issue(0, 0, 0, 64'd1000, 64'd3, 1'b0);
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check64("flush_out_valid", 64'(out_valid), 64'd0);
    check64("flush_ready", 64'(div_ready), 64'd1);
    repeat (70) step();
    run_op(0, 0, 0, 64'd9, 64'd3);

    // Request coinciding with flush in idle is dropped
    div_valid = 1'b1;
    div_src1  = 64'd9;
    div_src2  = 64'd0;
    flush     = 1'b1;
    step();
    div_valid = 1'b0;
    flush     = 1'b0;
    check64("flush_idle_ready", 64'(div_ready), 64'd1);
    repeat (3) step();

    // Reset mid-operation
    issue(1, 0, 0, 64'd12345, 64'd17, 1'b0);
    repeat (20) step();
    #2;
    rst_n = 1'b0;
    #1;
    check64("midreset_valid", 64'(out_valid), 64'd0);
    check64("midreset_result", out_result, 64'd0);
    check64("midreset_ready", 64'(div_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();

    // Randomized ops
    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom), 1'($urandom), 1'($urandom), rand_operand(0), rand_operand(1));
    end

    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV64M divide group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits beside the single-cycle ALU in the execute stage. The EXU issues a request over a valid/ready handshake, then stalls until the result handshake completes.
- Handles the RISC-V divide-by-zero and signed-overflow rules and W-form sign extension internally, so the EXU only muxes in the result.

Parameters:
- XLEN, 64, operand and result width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- div_valid  in  1  request valid.
- div_ready  out  1  unit idle, can accept a request.
- div_signed  in  1  1 = signed op (DIV/REM/DIVW/REMW).
- div_word  in  1  1 = W-form, uses low 32 bits of the operands.
- div_rem  in  1  1 = return remainder, 0 = return quotient.
- div_src1  in  XLEN  dividend.
- div_src2  in  XLEN  divisor.
- flush  in  1  pipeline flush; aborts any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  quotient or remainder.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, out_valid=0, out_result=0, iteration counter=0, all working registers 0. div_ready=1 as soon as reset releases.
- States: IDLE, CALC, DONE.
- div_ready is 1 only in IDLE, decoded from state with no input dependence.
- Accept condition: div_valid & div_ready & !flush at a rising edge. Operands and op bits are captured at that edge; later changes on the request inputs are ignored.
- Operand preparation at accept:
  - Width: W-form takes bits[31:0] of each operand, sign-extended if div_signed, zero-extended otherwise. Iteration count N=32 for W-form, 64 otherwise.
  - Signed ops divide the absolute values. Record qneg = sign(src1) XOR sign(src2) and rneg = sign(src1).
- Special cases, detected at accept. The unit goes directly IDLE->DONE, so out_valid rises one cycle after accept.
  - Divisor==0: quotient = all ones (at operand width); remainder = dividend.
  - Signed, dividend = most-negative value, divisor = -1: quotient = dividend; remainder = 0.
- CALC:
  - One quotient bit per cycle: shift the partial remainder left by 1, bring in the next dividend bit, subtract the divisor if the result is non-negative.
  - Counter runs 0..N-1. On the last iteration the state moves to DONE.
  - Normal latency: accept at edge t, out_valid high from edge t+N+1 (65 cycles for 64-bit, 33 for W-form).
- Result fixup, registered on entry to DONE:
  - Negate the quotient if qneg; negate the remainder if rneg.
  - Select quotient or remainder per div_rem.
  - W-form: sign-extend bit 31 of the selected result to XLEN. This applies to DIVUW/REMUW as well.
- DONE:
  - out_valid=1 and out_result held stable until out_valid & out_ready.
  - On that handshake: next state IDLE, out_valid drops at the next edge.
  - No new request can be accepted in the same cycle as the result handshake; div_ready rises the cycle after.
- Flush:
  - Any state -> IDLE at the next edge; out_valid=0 and no result is delivered.
  - Flush in DONE discards the result even if out_ready is high in the same cycle.
  - Flush in the same cycle as div_valid in IDLE: the request is dropped.
- Reset asserted mid-operation: immediate return to reset values. No partial result is visible.

Test Plan:
- DIVU 100/7, div_rem=0 -> out_result=14, out_valid first high 65 cycles after accept. Repeat with div_rem=1 -> 2.
- DIV src1=-7 (0xFFFF_FFFF_FFFF_FFF9), src2=2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3). REM same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- Divide by zero:
  - DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 5/0 -> 5.
  - out_valid high exactly 1 cycle after accept.
  - DIVW 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
  - DIVW src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- DIVUW 0x1234_5678_FFFF_FFFE / 1 -> 0xFFFF_FFFF_FFFF_FFFE (upper bits ignored, bit-31 sign extension).
  - Check latency is 33 cycles.
- Handshake and abort:
  - Hold out_ready=0 for 5 cycles in DONE -> out_result stable, out_valid held; div_ready=0 throughout.
  - Separately, assert flush 10 cycles into CALC -> out_valid never rises, div_ready=1 on the next cycle.
  - A following DIVU 9/3 then returns 3 correctly.
